// File: rtl/denise_colortable_ram_mf_pkg.sv
// Shared sizing constants for the Denise colour-table RAM.
package denise_colortable_ram_mf_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int BE_W   = 4;

endpackage : denise_colortable_ram_mf_pkg

// File: rtl/denise_colortable_ram_mf.sv
// Denise colour-table RAM: 256 x 32 simple dual-port RAM. It has one byte-enabled
// write port, one registered read port, and a shared clock enable. A read and a
// write to the same address at one edge return the old contents. Reset clears
// only the output register and never the array.
module denise_colortable_ram_mf
  import denise_colortable_ram_mf_pkg::*;
#(
  parameter int ADDR_W = denise_colortable_ram_mf_pkg::ADDR_W,
  parameter int DATA_W = denise_colortable_ram_mf_pkg::DATA_W,
  parameter int DEPTH  = denise_colortable_ram_mf_pkg::DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic              wren,
  input  logic [BE_W-1:0]   byteena_a,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] rdaddress,
  output logic [DATA_W-1:0] q
);

  // The array starts at zero through its declaration initialiser.
  // No always block ever clears it, so it still maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              wr_fire;
  logic [DATA_W-1:0] q_p1;

  // A write fires only while reset is inactive and the clock enable is high.
  always_comb begin
    wr_fire = reset_n & enable & wren;
  end

  // ---- stage p0 -> p1 : array update and registered read ----

  // Byte-lane write: only lanes with a set byteena_a bit take the new data.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byteena_a[b]) begin
          mem[wraddress][8*b +: 8] <= data[8*b +: 8];
        end
      end
    end
  end

  // Registered read: it samples the pre-write contents, holds while disabled and clears on reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q_p1 <= '0;
    end else if (enable) begin
      q_p1 <= mem[rdaddress];
    end
  end

  assign q = q_p1;

endmodule : denise_colortable_ram_mf

// File: tb/tb_denise_colortable_ram_mf.sv
// Bench for the Denise colour-table RAM. It runs directed steps and randomized
// traffic, and it compares q against a behavioural memory model.
module tb_denise_colortable_ram_mf;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [7:0]  wraddress;
  logic        wren;
  logic [3:0]  byteena_a;
  logic [31:0] data;
  logic [7:0]  rdaddress;
  logic [31:0] q;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [256];
  logic [31:0] model_q;

  denise_colortable_ram_mf dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .wraddress (wraddress),
    .wren      (wren),
    .byteena_a (byteena_a),
    .data      (data),
    .rdaddress (rdaddress),
    .q         (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock: drive the inputs, let the edge happen, advance the model, then compare q.
  task automatic cycle(input string tag, input logic rst_n, input logic en,
                       input logic we, input logic [7:0] wa, input logic [3:0] be,
                       input logic [31:0] d, input logic [7:0] ra);
    logic [31:0] old_word;
    reset_n   = rst_n;
    enable    = en;
    wren      = we;
    wraddress = wa;
    byteena_a = be;
    data      = d;
    rdaddress = ra;
    @(posedge clock);
    #1;
    // Read sees the contents before this edge's write.
    if (!rst_n)  model_q = 32'h0;
    else if (en) model_q = model_mem[ra];
    if (rst_n && en && we) begin
      old_word = model_mem[wa];
      for (int b = 0; b < 4; b++)
        if (be[b]) old_word[8*b +: 8] = d[8*b +: 8];
      model_mem[wa] = old_word;
    end
    checks++;
    assert (q === model_q) else begin
      errors++;
      $error("FAIL %s q=%h expected=%h", tag, q, model_q);
    end
  endtask

  // Compare q against a value written out in the directed step.
  task automatic expect_q(input string tag, input logic [31:0] exp);
    checks++;
    assert (q === exp) else begin
      errors++;
      $error("FAIL %s q=%h expected=%h", tag, q, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    model_q = 32'h0;

    // Reset, then confirm that q has cleared.
    cycle("reset0", 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 8'h00);
    cycle("reset1", 1'b0, 1'b1, 1'b1, 8'h00, 4'hF, 32'hDEAD_BEEF, 8'h00);
    expect_q("reset_q", 32'h0);
    cycle("pwrup_zero", 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 8'h00);
    expect_q("pwrup_zero_lit", 32'h0);

    // Full-word write, then the read one edge later.
    cycle("wr1f", 1'b1, 1'b1, 1'b1, 8'h1F, 4'hF, 32'h0ABC_0DEF, 8'h00);
    cycle("rd1f", 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 8'h1F);
    expect_q("rd1f_lit", 32'h0ABC_0DEF);

    // Partial write through the lower two lanes only.
    cycle("wr1f_be3", 1'b1, 1'b1, 1'b1, 8'h1F, 4'b0011, 32'h0000_0123, 8'h00);
    cycle("rd1f_be3", 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 8'h1F);
    expect_q("rd1f_be3_lit", 32'h0ABC_0123);

    // byteena 0000 leaves the entry untouched.
    cycle("wr1f_be0", 1'b1, 1'b1, 1'b1, 8'h1F, 4'b0000, 32'hFFFF_FFFF, 8'h00);
    cycle("rd1f_be0", 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 8'h1F);
    expect_q("rd1f_be0_lit", 32'h0ABC_0123);

    // Same-address read and write at one edge return the old data.
    cycle("wr05_a", 1'b1, 1'b1, 1'b1, 8'h05, 4'hF, 32'h2222_2222, 8'h00);
    cycle("rw05", 1'b1, 1'b1, 1'b1, 8'h05, 4'hF, 32'h1111_1111, 8'h05);
    expect_q("rw05_old", 32'h2222_2222);
    cycle("rd05", 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 8'h05);
    expect_q("rd05_new", 32'h1111_1111);

    // With the clock enable low, writes are suppressed and q holds its value.
    cycle("wr80", 1'b1, 1'b1, 1'b1, 8'h80, 4'hF, 32'h1234_5678, 8'h1F);
    cycle("dis0", 1'b1, 1'b0, 1'b1, 8'h80, 4'hF, 32'hFFFF_FFFF, 8'h80);
    expect_q("dis0_hold", 32'h0ABC_0123);
    cycle("dis1", 1'b1, 1'b0, 1'b1, 8'h80, 4'hF, 32'hFFFF_FFFF, 8'h05);
    expect_q("dis1_hold", 32'h0ABC_0123);
    cycle("rd80", 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 8'h80);
    expect_q("rd80_kept", 32'h1234_5678);

    // Reset clears q but keeps the array; it also wins over enable.
    cycle("wrE0", 1'b1, 1'b1, 1'b1, 8'hE0, 4'hF, 32'h0000_0FFF, 8'hE0);
    cycle("rstE0", 1'b0, 1'b1, 1'b1, 8'hE0, 4'hF, 32'hAAAA_AAAA, 8'hE0);
    expect_q("rst_q0", 32'h0);
    cycle("rdE0", 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 8'hE0);
    expect_q("rdE0_kept", 32'h0000_0FFF);

    // Sweep every address with address-dependent data, then read each entry back.
    for (int a = 0; a < 256; a++)
      cycle("sweep_wr", 1'b1, 1'b1, 1'b1, 8'(a), 4'hF,
            (32'(a) * 32'h0101_0101) ^ 32'hA500_005A, 8'($urandom_range(0, 255)));
    for (int a = 0; a < 256; a++)
      cycle("sweep_rd", 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 8'(a));
    cycle("rd00", 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 8'h00);
    expect_q("rd00_lit", 32'hA500_005A);
    cycle("rdFF", 1'b1, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0, 8'hFF);
    expect_q("rdFF_lit", 32'h5AFF_FFA5);

    // Randomized traffic with occasional disables and resets.
    for (int i = 0; i < 600; i++) begin
      cycle("rand", ($urandom_range(0, 15) != 0), ($urandom_range(0, 7) != 0),
            1'($urandom), 8'($urandom), 4'($urandom), $urandom,
            ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_denise_colortable_ram_mf
